burst_port_arbiter: RTL

- Shares the single burst-request port of the AXI master bridge (rd/wr req, len, addr, data handshake, finish) between two burst clients, c0 and c1.
- Each client has the same interface the memory tester drives today.
- Four requesters (c0_wr, c0_rd, c1_wr, c1_rd) are round-robin arbitrated. One burst is outstanding at a time.
- Grant holds until the master reports finish. The data path is steered to the granted requester.

---
 rtl/burst_port_arbiter_pkg.sv | 23 ++
 rtl/burst_port_arbiter_rr_pick4.sv | 22 ++
 rtl/burst_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/burst_port_arbiter_pkg.sv
// Shared encodings and default widths for the two-client burst port arbiter.
`timescale 1ns/1ps
package burst_port_arbiter_pkg;

  localparam int DEF_DATA_BITS = 64;
  localparam int DEF_ADDR_BITS = 32;
  localparam int DEF_LEN_BITS  = 10;

  // Requester index doubles as grant_id = {client, is_read}.
  localparam logic [1:0] REQ_C0_WR = 2'd0;
  localparam logic [1:0] REQ_C0_RD = 2'd1;
  localparam logic [1:0] REQ_C1_WR = 2'd2;
  localparam logic [1:0] REQ_C1_RD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WR_BUSY,
    RD_BUSY,
    GAP
  } state_e;

endpackage

// File: rtl/burst_port_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set req at or after ptr.
`timescale 1ns/1ps
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  // Walk from the farthest slot to the nearest so the nearest hit wins.
  always_comb begin
    winner = ptr;
    any    = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_port_arbiter.sv
// Shares one master-bridge burst port between two clients (wr+rd each):
// round-robin grant, one burst in flight, zero-latency data/finish steering.
`timescale 1ns/1ps
module burst_port_arbiter
  import burst_port_arbiter_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LEN_BITS  = DEF_LEN_BITS
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 rst_n,
  // client 0
  input  logic                 c0_rd_burst_req,
  input  logic                 c0_wr_burst_req,
  input  logic [LEN_BITS-1:0]  c0_rd_burst_len,
  input  logic [LEN_BITS-1:0]  c0_wr_burst_len,
  input  logic [ADDR_BITS-1:0] c0_rd_burst_addr,
  input  logic [ADDR_BITS-1:0] c0_wr_burst_addr,
  input  logic [DATA_BITS-1:0] c0_wr_burst_data,
  output logic                 c0_wr_burst_data_req,
  output logic                 c0_rd_burst_data_valid,
  output logic [DATA_BITS-1:0] c0_rd_burst_data,
  output logic                 c0_rd_burst_finish,
  output logic                 c0_wr_burst_finish,
  // client 1
  input  logic                 c1_rd_burst_req,
  input  logic                 c1_wr_burst_req,
  input  logic [LEN_BITS-1:0]  c1_rd_burst_len,
  input  logic [LEN_BITS-1:0]  c1_wr_burst_len,
  input  logic [ADDR_BITS-1:0] c1_rd_burst_addr,
  input  logic [ADDR_BITS-1:0] c1_wr_burst_addr,
  input  logic [DATA_BITS-1:0] c1_wr_burst_data,
  output logic                 c1_wr_burst_data_req,
  output logic                 c1_rd_burst_data_valid,
  output logic [DATA_BITS-1:0] c1_rd_burst_data,
  output logic                 c1_rd_burst_finish,
  output logic                 c1_wr_burst_finish,
  // master bridge
  output logic                 m_rd_burst_req,
  output logic                 m_wr_burst_req,
  output logic [LEN_BITS-1:0]  m_rd_burst_len,
  output logic [LEN_BITS-1:0]  m_wr_burst_len,
  output logic [ADDR_BITS-1:0] m_rd_burst_addr,
  output logic [ADDR_BITS-1:0] m_wr_burst_addr,
  input  logic                 m_wr_burst_data_req,
  output logic [DATA_BITS-1:0] m_wr_burst_data,
  input  logic                 m_rd_burst_data_valid,
  input  logic [DATA_BITS-1:0] m_rd_burst_data,
  input  logic                 m_rd_burst_finish,
  input  logic                 m_wr_burst_finish,
  // status
  output logic                 busy,
  output logic [1:0]           grant_id
);

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           grant_q, grant_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 zl_fin_q, zl_fin_d;

  logic [3:0]           req_vec;
  logic [LEN_BITS-1:0]  req_len  [4];
  logic [ADDR_BITS-1:0] req_addr [4];
  logic [1:0]           winner;
  logic                 any_req;

  assign req_vec = {c1_rd_burst_req, c1_wr_burst_req, c0_rd_burst_req, c0_wr_burst_req};

  assign req_len[REQ_C0_WR]  = c0_wr_burst_len;
  assign req_len[REQ_C0_RD]  = c0_rd_burst_len;
  assign req_len[REQ_C1_WR]  = c1_wr_burst_len;
  assign req_len[REQ_C1_RD]  = c1_rd_burst_len;
  assign req_addr[REQ_C0_WR] = c0_wr_burst_addr;
  assign req_addr[REQ_C0_RD] = c0_rd_burst_addr;
  assign req_addr[REQ_C1_WR] = c1_wr_burst_addr;
  assign req_addr[REQ_C1_RD] = c1_rd_burst_addr;

  rr_pick4 u_pick (
    .req    (req_vec),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    len_d    = len_q;
    addr_d   = addr_q;
    zl_fin_d = 1'b0;
    unique case (state_q)
      IDLE: if (any_req) state_d = ARB;
      ARB: begin
        if (any_req) begin
          grant_d = winner;
          ptr_d   = winner + 2'd1;
          if (req_len[winner] == '0) begin
            // Zero-length bursts complete locally; the master never sees them.
            zl_fin_d = 1'b1;
            state_d  = GAP;
          end else begin
            len_d   = req_len[winner];
            addr_d  = req_addr[winner];
            state_d = winner[0] ? RD_BUSY : WR_BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_BUSY: if (m_wr_burst_finish) state_d = GAP;
      RD_BUSY: if (m_rd_burst_finish) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= REQ_C0_WR;
      grant_q  <= 2'b11;
      len_q    <= '0;
      addr_q   <= '0;
      zl_fin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      zl_fin_q <= zl_fin_d;
    end
  end

  logic wr_busy, rd_busy, wr_beat, rd_beat, wr_done, rd_done;

  assign wr_busy = (state_q == WR_BUSY);
  assign rd_busy = (state_q == RD_BUSY);

  assign m_wr_burst_req  = wr_busy;
  assign m_rd_burst_req  = rd_busy;
  assign m_wr_burst_len  = len_q;
  assign m_rd_burst_len  = len_q;
  assign m_wr_burst_addr = addr_q;
  assign m_rd_burst_addr = addr_q;
  assign busy            = wr_busy | rd_busy;
  assign grant_id        = grant_q;

  // Handshakes only pass while the matching burst is granted; strays are dropped.
  assign wr_beat = m_wr_burst_data_req & wr_busy;
  assign rd_beat = m_rd_burst_data_valid & rd_busy;
  assign wr_done = (m_wr_burst_finish & wr_busy) | zl_fin_q;
  assign rd_done = (m_rd_burst_finish & rd_busy) | zl_fin_q;

  assign c0_wr_burst_data_req   = wr_beat & (grant_q == REQ_C0_WR);
  assign c1_wr_burst_data_req   = wr_beat & (grant_q == REQ_C1_WR);
  assign c0_rd_burst_data_valid = rd_beat & (grant_q == REQ_C0_RD);
  assign c1_rd_burst_data_valid = rd_beat & (grant_q == REQ_C1_RD);
  assign c0_wr_burst_finish     = wr_done & (grant_q == REQ_C0_WR);
  assign c1_wr_burst_finish     = wr_done & (grant_q == REQ_C1_WR);
  assign c0_rd_burst_finish     = rd_done & (grant_q == REQ_C0_RD);
  assign c1_rd_burst_finish     = rd_done & (grant_q == REQ_C1_RD);

  assign c0_rd_burst_data = m_rd_burst_data;
  assign c1_rd_burst_data = m_rd_burst_data;

  always_comb begin
    m_wr_burst_data = '0;
    if (wr_busy) m_wr_burst_data = (grant_q == REQ_C1_WR) ? c1_wr_burst_data : c0_wr_burst_data;
  end

endmodule
